// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the operand forwarding / hazard unit.
package fwd_pkg;

    localparam int REG_CODE_W   = 4;
    localparam int DEF_DW       = 32;
    localparam int DEF_NUM_REGS = 16;

    // Number of bits needed to encode values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result = int'(i) + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Single read-port forwarding mux: the lowest-index matching source wins,
// otherwise the register-file value passes through.
module fwd_mux
    import fwd_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int DW      = DEF_DW
) (
    input  logic [NUM_SRC-1:0]            src_en,
    input  logic [REG_CODE_W*NUM_SRC-1:0] src_code,
    input  logic [DW*NUM_SRC-1:0]         src_data,
    input  logic [REG_CODE_W-1:0]         rd_code,
    input  logic [DW-1:0]                 rd_reg,
    output logic [DW-1:0]                 fwd_data
);

    logic found;

    always_comb begin
        fwd_data = rd_reg;
        found    = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!found && src_en[i] &&
                (src_code[i*REG_CODE_W +: REG_CODE_W] == rd_code)) begin
                fwd_data = src_data[i*DW +: DW];
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, per-register latency scoreboard with decode stall,
// and a saturating stall-cycle statistics counter.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int  NUM_RD   = 3,
    parameter int  NUM_SRC  = 2,
    parameter int  DW       = DEF_DW,
    parameter int  NUM_REGS = DEF_NUM_REGS,
    parameter int  MAX_LAT  = 7,
    localparam int CW       = clog2(MAX_LAT + 1)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_SRC-1:0]             i_src_en,
    input  logic [REG_CODE_W*NUM_SRC-1:0]  i_src_code,
    input  logic [DW*NUM_SRC-1:0]          i_src_data,
    input  logic [NUM_RD-1:0]              i_rd_used,
    input  logic [REG_CODE_W*NUM_RD-1:0]   i_rd_code,
    input  logic [DW*NUM_RD-1:0]           i_rd_reg,
    output logic [DW*NUM_RD-1:0]           o_rd_reg,
    input  logic                           i_dec_valid,
    input  logic                           i_iss_valid,
    input  logic [REG_CODE_W-1:0]          i_iss_code,
    input  logic [CW-1:0]                  i_iss_lat,
    input  logic                           i_flush,
    input  logic                           i_cnt_clr,
    output logic                           o_stall,
    output logic                           o_busy,
    output logic [15:0]                    o_stall_cnt
);

    logic [CW-1:0] pend_cnt [NUM_REGS];
    logic          hit;
    logic          issue;

    for (genvar j = 0; j < NUM_RD; j++) begin : g_port
        fwd_mux #(
            .NUM_SRC (NUM_SRC),
            .DW      (DW)
        ) u_mux (
            .src_en   (i_src_en),
            .src_code (i_src_code),
            .src_data (i_src_data),
            .rd_code  (i_rd_code[j*REG_CODE_W +: REG_CODE_W]),
            .rd_reg   (i_rd_reg[j*DW +: DW]),
            .fwd_data (o_rd_reg[j*DW +: DW])
        );
    end

    // A pending register stalls decode even when a source could forward it.
    always_comb begin
        hit = 1'b0;
        for (int unsigned j = 0; j < NUM_RD; j++) begin
            if (i_rd_used[j] &&
                (pend_cnt[i_rd_code[j*REG_CODE_W +: REG_CODE_W]] != '0)) begin
                hit = 1'b1;
            end
        end
        o_stall = i_dec_valid & hit;
    end

    always_comb begin
        o_busy = 1'b0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (pend_cnt[r] != '0) begin
                o_busy = 1'b1;
            end
        end
    end

    assign issue = i_iss_valid & ~o_stall & ~i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                pend_cnt[r] <= '0;
            end
        end else if (i_flush) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                pend_cnt[r] <= '0;
            end
        end else begin
            // A new issue overrides the countdown of the same register.
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (issue && (i_iss_lat != '0) && (i_iss_code == REG_CODE_W'(r))) begin
                    pend_cnt[r] <= i_iss_lat;
                end else if (pend_cnt[r] != '0) begin
                    pend_cnt[r] <= pend_cnt[r] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
        end else if (i_cnt_clr) begin
            o_stall_cnt <= '0;
        end else if (o_stall && (o_stall_cnt != '1)) begin
            o_stall_cnt <= o_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit against a time-stamp based reference model.
module tb_fwd_hazard_unit;

    localparam int NUM_RD   = 3;
    localparam int NUM_SRC  = 2;
    localparam int DW       = 32;
    localparam int NUM_REGS = 16;
    localparam int MAX_LAT  = 7;
    localparam int CW       = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_SRC-1:0]    src_en;
    logic [4*NUM_SRC-1:0]  src_code;
    logic [DW*NUM_SRC-1:0] src_data;
    logic [NUM_RD-1:0]     rd_used;
    logic [4*NUM_RD-1:0]   rd_code;
    logic [DW*NUM_RD-1:0]  rd_reg;
    logic [DW*NUM_RD-1:0]  rd_out;
    logic                  dec_valid;
    logic                  iss_valid;
    logic [3:0]            iss_code;
    logic [CW-1:0]         iss_lat;
    logic                  flush;
    logic                  cnt_clr;
    logic                  stall;
    logic                  busy;
    logic [15:0]           stall_cnt;

    int total = 0;
    int bad   = 0;

    // Model: absolute edge count; a register is pending while cyc < ready[reg].
    int cyc = 0;
    int ready [NUM_REGS];
    int m_cnt = 0;

    fwd_hazard_unit #(
        .NUM_RD   (NUM_RD),
        .NUM_SRC  (NUM_SRC),
        .DW       (DW),
        .NUM_REGS (NUM_REGS),
        .MAX_LAT  (MAX_LAT)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_src_en    (src_en),
        .i_src_code  (src_code),
        .i_src_data  (src_data),
        .i_rd_used   (rd_used),
        .i_rd_code   (rd_code),
        .i_rd_reg    (rd_reg),
        .o_rd_reg    (rd_out),
        .i_dec_valid (dec_valid),
        .i_iss_valid (iss_valid),
        .i_iss_code  (iss_code),
        .i_iss_lat   (iss_lat),
        .i_flush     (flush),
        .i_cnt_clr   (cnt_clr),
        .o_stall     (stall),
        .o_busy      (busy),
        .o_stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic m_pending(input logic [3:0] code);
        return cyc < ready[code];
    endfunction

    function automatic logic m_stall();
        if (!dec_valid) return 1'b0;
        for (int j = 0; j < NUM_RD; j++) begin
            if (rd_used[j] && m_pending(rd_code[4*j +: 4])) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic m_busy();
        for (int r = 0; r < NUM_REGS; r++) begin
            if (cyc < ready[r]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] m_fwd(input int j);
        logic [3:0] c;
        c = rd_code[4*j +: 4];
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_en[i] && src_code[4*i +: 4] == c) return src_data[DW*i +: DW];
        end
        return rd_reg[DW*j +: DW];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) ready[r] = 0;
            m_cnt = 0;
        end else begin
            logic s;
            s = m_stall();
            cyc++;
            if (cnt_clr) m_cnt = 0;
            else if (s && m_cnt < 65535) m_cnt++;
            if (flush) begin
                for (int r = 0; r < NUM_REGS; r++) ready[r] = 0;
            end else if (iss_valid && !s && iss_lat != 0) begin
                ready[iss_code] = cyc + int'(iss_lat);
            end
        end
    end

    always @(negedge clk) begin
        for (int j = 0; j < NUM_RD; j++) begin
            chk("model_rd_reg", rd_out[DW*j +: DW], m_fwd(j));
        end
        chk("model_stall", 32'(stall), 32'(m_stall()));
        chk("model_busy", 32'(busy), 32'(m_busy()));
        chk("model_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    end

    initial begin
        rst_n = 1'b0;
        src_en = '0; src_code = '0; src_data = '0;
        rd_used = '0; rd_code = '0;
        rd_reg = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        dec_valid = 1'b0; iss_valid = 1'b0; iss_code = '0; iss_lat = '0;
        flush = 1'b0; cnt_clr = 1'b0;

        // Reset holds everything idle even with traffic present and clocks running.
        #2;
        dec_valid = 1'b1; rd_used = 3'b111; iss_valid = 1'b1; iss_lat = 3'd5;
        #1;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_cnt", 32'(stall_cnt), 32'd0);
        tick();
        chk("reset_busy_clocked", 32'(busy), 32'd0);

        // Release reset and issue code 2, lat 3 at the very first edge.
        rst_n = 1'b1;
        dec_valid = 1'b0; rd_used = '0;
        iss_valid = 1'b1; iss_code = 4'd2; iss_lat = 3'd3;
        src_en = 2'b11; src_code = {4'd3, 4'd3}; src_data = {32'h0000_BBBB, 32'h0000_AAAA};
        rd_code[3:0] = 4'd3;
        #1;
        chk("fwd_youngest", rd_out[31:0], 32'h0000_AAAA);
        tick();
        chk("first_issue_busy", 32'(busy), 32'd1);

        iss_valid = 1'b0; dec_valid = 1'b1; rd_used = 3'b001; rd_code[3:0] = 4'd2;
        #1;
        chk("raw_stall_c1", 32'(stall), 32'd1);
        tick();
        chk("raw_stall_c2", 32'(stall), 32'd1);
        tick();
        chk("raw_stall_c3", 32'(stall), 32'd1);
        tick();
        chk("raw_stall_done", 32'(stall), 32'd0);
        chk("raw_stall_cnt", 32'(stall_cnt), 32'd3);

        // Unused operand never stalls.
        rd_used = '0; iss_valid = 1'b1; iss_code = 4'd2; iss_lat = 3'd3;
        tick();
        iss_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("unused_no_stall", 32'(stall), 32'd0);
            tick();
        end
        chk("unused_cnt_kept", 32'(stall_cnt), 32'd3);

        // Flush clears the scoreboard and blocks a simultaneous issue.
        dec_valid = 1'b0; iss_valid = 1'b1; iss_code = 4'd4; iss_lat = 3'd5;
        tick();
        chk("flush_pre_busy", 32'(busy), 32'd1);
        iss_code = 4'd6; iss_lat = 3'd7; flush = 1'b1;
        tick();
        flush = 1'b0; iss_valid = 1'b0;
        #1;
        chk("flush_busy", 32'(busy), 32'd0);

        // Older source only; unmatched port falls back to the register file.
        src_code = {4'd5, 4'd3}; src_data = {32'h0000_1234, 32'h0000_AAAA};
        rd_code[7:4] = 4'd5; rd_reg[63:32] = 32'h0;
        rd_code[11:8] = 4'd9; rd_reg[95:64] = 32'h0000_CAFE;
        #1;
        chk("fwd_older_src", rd_out[63:32], 32'h0000_1234);
        chk("fwd_no_match", rd_out[95:64], 32'h0000_CAFE);

        // Pending register stalls even though src1 would forward it.
        dec_valid = 1'b1; rd_used = 3'b010;
        iss_valid = 1'b1; iss_code = 4'd5; iss_lat = 3'd2;
        tick();
        iss_valid = 1'b0;
        #1;
        chk("pending_beats_fwd", 32'(stall), 32'd1);
        tick();
        tick();
        chk("pending_cleared", 32'(stall), 32'd0);

        // Latency 0 never marks the register pending.
        rd_code[7:4] = 4'd7; iss_valid = 1'b1; iss_code = 4'd7; iss_lat = 3'd0;
        tick();
        iss_valid = 1'b0;
        #1;
        chk("lat0_stall", 32'(stall), 32'd0);
        chk("lat0_busy", 32'(busy), 32'd0);

        // Reissue overwrites a long countdown with a short one.
        dec_valid = 1'b0; iss_valid = 1'b1; iss_code = 4'd8; iss_lat = 3'd7;
        tick();
        iss_lat = 3'd1;
        tick();
        iss_valid = 1'b0;
        #1;
        chk("overwrite_busy", 32'(busy), 32'd1);
        tick();
        chk("overwrite_done", 32'(busy), 32'd0);

        // Saturation: six stall cycles in every seven, reissuing on the idle cycle.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_cnt", 32'(stall_cnt), 32'd0);
        rd_used = 3'b001; rd_code[3:0] = 4'd2;
        iss_valid = 1'b1; iss_code = 4'd2; iss_lat = 3'd7;
        for (int k = 0; k < 76500; k++) begin
            dec_valid = (k % 7) != 0;
            tick();
        end
        chk("sat_cnt", 32'(stall_cnt), 32'h0000_FFFF);
        cnt_clr = 1'b1;
        #1;
        chk("clr_during_stall", 32'(stall), 32'd1);
        tick();
        cnt_clr = 1'b0;
        chk("clr_wins", 32'(stall_cnt), 32'd0);
        tick();
        chk("count_after_clr", 32'(stall_cnt), 32'd1);

        // Asynchronous reset mid-cycle.
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", 32'(stall_cnt), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        #20;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter NUM_RD, default 3: number of operand read ports.
REQ-002 Parameter NUM_SRC, default 2: number of forwarding sources; index 0 is the youngest stage (EX).
REQ-003 Parameter DW, default 32: data width.
REQ-004 Parameter NUM_REGS, default 16: architectural registers, addressed by 4-bit codes.
REQ-005 Parameter MAX_LAT, default 7: maximum result latency; CW = clog2(MAX_LAT+1).
REQ-006 i_clk  in  1  single clock, rising edge.
REQ-007 i_rst_n  in  1  asynchronous, active-low reset.
REQ-008 i_src_en  in  NUM_SRC  forwarding source i writes a register.
REQ-009 i_src_code  in  4*NUM_SRC  destination code of source i.
REQ-010 i_src_data  in  DW*NUM_SRC  result value of source i.
REQ-011 i_rd_used  in  NUM_RD  read port j carries a real operand.
REQ-012 i_rd_code  in  4*NUM_RD  register code of port j.
REQ-013 i_rd_reg  in  DW*NUM_RD  register-file value for port j.
REQ-014 o_rd_reg  out  DW*NUM_RD  forwarded operand for port j.
REQ-015 i_dec_valid  in  1  decode stage holds a valid instruction.
REQ-016 i_iss_valid, i_iss_code[4], i_iss_lat[CW]  in  issuing instruction writes i_iss_code after i_iss_lat cycles.
REQ-017 i_flush  in  1  pipeline flush.
REQ-018 i_cnt_clr  in  1  clear stall statistics counter.
REQ-019 o_stall  out  1  hold decode this cycle.
REQ-020 o_busy  out  1  at least one register result is pending.
REQ-021 o_stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-022 Port j output: i_src_data of the lowest-index source i with i_src_en[i] and i_src_code[i]==i_rd_code[j]; otherwise i_rd_reg[j]; combinational, zero latency.
REQ-023 Matches from several sources on the same port: the lowest index wins (youngest value).
REQ-024 Scoreboard: one CW-bit countdown per register; nonzero = result pending.
REQ-025 Issue accepted at the clock edge only when i_iss_valid=1, o_stall=0 and i_flush=0; the counter of i_iss_code loads i_iss_lat.
REQ-026 i_iss_lat=0 is a single-cycle op; the counter is not loaded.
REQ-027 Nonzero counters not being loaded decrement by 1 each cycle, floor 0.
REQ-028 Issue to an already pending register overwrites its counter (the issue wins over the decrement).
REQ-029 o_stall = i_dec_valid AND (some port j with i_rd_used[j]=1 has a nonzero counter for i_rd_code[j]); combinational.
REQ-030 A pending register is not forwarded: a pending counter forces a stall even if a source matches.
REQ-031 i_flush=1 clears all counters at the next edge, overriding issue and decrement.
REQ-032 o_busy = OR of all counters != 0.
REQ-033 o_stall_cnt increments each cycle o_stall=1 and saturates at 16'hFFFF.
REQ-034 i_cnt_clr forces o_stall_cnt to 0 and wins over increment.

Reset
REQ-035 While i_rst_n=0, all counters and o_stall_cnt are 0, so o_stall=0 and o_busy=0 regardless of the clock.
REQ-036 Reset asserted mid-operation discards all pending entries immediately.
REQ-037 The first accepted issue is at the first rising edge after deassertion.

Structure
REQ-038 The shared package fwd_pkg holds REG_CODE_W=4, the default DW and NUM_REGS, and the clog2 helper.
REQ-039 One sub-module, fwd_mux (a single-port priority forward mux), is instantiated NUM_RD times via generate.
REQ-040 Scoreboard and statistics counter live in the top level; there are no latches and every case is fully specified.

Verification
REQ-041 src0 en, code 3, data 0xAAAA; src1 en, code 3, data 0xBBBB; port0 code 3 -> o_rd_reg[0]=0xAAAA.
REQ-042 Only src1 matches code 5 with 0x1234; port1 code 5; register file 0x0 -> 0x1234; no match -> register-file value.
REQ-043 Issue code 2, lat 3; next cycle decode port0 code 2, used -> o_stall=1 for 3 cycles, then 0; o_stall_cnt=3.
REQ-044 Same as REQ-043 but i_rd_used=0 on the port -> o_stall stays 0.
REQ-045 Issue code 4, lat 5; flush after 1 cycle -> o_busy=0 next cycle; simultaneous issue is ignored.
REQ-046 Force 65537 stall cycles -> o_stall_cnt=0xFFFF; then i_cnt_clr -> 0; reset asserted mid-count -> 0 asynchronously.
